// File: rtl/seven_seg_reader.sv
// Recovers hex digits from a snooped active-low multiplexed 7-seg bus; captures STABLE_CYCLES+2 edges after a change, no backpressure.
// Define SEVEN_SEG_LAMP_TEST_EN to recognise the all-digits/all-segments lamp test pattern.
module seven_seg_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          seg_n,
    input  logic [DIGITS-1:0]   an_n,
    output logic [4*DIGITS-1:0] value,
    output logic [DIGITS-1:0]   digit_valid,
    output logic                frame_valid,
    output logic                pattern_err,
    output logic [2:0]          err_digit,
    output logic                lamp_test
);

    localparam int BW = DIGITS + 7;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic {SETTLE, HOLD} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [BW-1:0]     s1, s2, prev;
    logic              capture;

    logic [DIGITS-1:0] an_low, an_sel, seen, seen_nxt;
    logic [6:0]        seg;
    logic              one_hot, lamp_hit, cap_digit, frame_done;
    logic [2:0]        dig_idx;
    logic [4:0]        dec;

    // Returns {legal, hex}; anything outside the 16 glyphs is not legal.
    function automatic logic [4:0] decode(input logic [6:0] g);
        case (g)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0000100: decode = 5'h19;
            7'b0001000: decode = 5'h1A;
            7'b1100000: decode = 5'h1B;
            7'b0110001: decode = 5'h1C;
            7'b1000010: decode = 5'h1D;
            7'b0110000: decode = 5'h1E;
            7'b0111000: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        if (s2 != prev) begin
            cnt_nxt   = '0;
            state_nxt = SETTLE;
        end else if (state == SETTLE) begin
            if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                capture   = 1'b1;
                cnt_nxt   = '0;
                state_nxt = HOLD;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_comb begin
        an_low  = ~s2[BW-1:7];
        seg     = s2[6:0];
        dec     = decode(seg);
        one_hot = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
        dig_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_low[i]) dig_idx = 3'(i);
        end
`ifdef SEVEN_SEG_LAMP_TEST_EN
        lamp_hit = capture && (an_low == '1) && (seg == 7'b0000000);
`else
        lamp_hit = 1'b0;
`endif
        // Lamp test wins over a single-digit "8" when DIGITS == 1.
        cap_digit  = capture && one_hot && !lamp_hit;
        an_sel     = cap_digit ? an_low : '0;
        frame_done = &seen;
        seen_nxt   = (frame_done ? '0 : seen) | an_sel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1          <= '0;
            s2          <= '0;
            prev        <= '0;
            state       <= SETTLE;
            cnt         <= '0;
            seen        <= '0;
            value       <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            err_digit   <= '0;
        end else begin
            s1          <= {an_n, seg_n};
            s2          <= s1;
            prev        <= s2;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            seen        <= seen_nxt;
            frame_valid <= frame_done;
            pattern_err <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                if (an_sel[i]) begin
                    if (dec[4]) begin
                        value[4*i +: 4] <= dec[3:0];
                        digit_valid[i]  <= 1'b1;
                    end else if (seg == BLANK) begin
                        value[4*i +: 4] <= 4'h0;
                        digit_valid[i]  <= 1'b0;
                    end else begin
                        digit_valid[i]  <= 1'b0;
                    end
                end
            end
            if (cap_digit && !dec[4] && seg != BLANK) begin
                pattern_err <= 1'b1;
                err_digit   <= dig_idx;
            end
        end
    end

`ifdef SEVEN_SEG_LAMP_TEST_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lamp_test <= 1'b0;
        end else if (capture) begin
            lamp_test <= lamp_hit;
        end
    end
`else
    assign lamp_test = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader with a pulse scoreboard for pattern_err and frame_valid.
module tb_seven_seg_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  an_n = 4'hF;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        pattern_err;
    logic [2:0]  err_digit;
    logic        lamp_test;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_value;
    logic [3:0]  m_valid;
    logic [3:0]  m_seen;
    logic        m_lamp;
    int          err_q[$];
    logic [15:0] frame_q[$];

    seven_seg_reader #(.DIGITS(4), .STABLE_CYCLES(4), .CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .value       (value),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err),
        .err_digit   (err_digit),
        .lamp_test   (lamp_test)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int h);
        case (h)
            0:  glyph = 7'b0000001;  1:  glyph = 7'b1001111;
            2:  glyph = 7'b0010010;  3:  glyph = 7'b0000110;
            4:  glyph = 7'b1001100;  5:  glyph = 7'b0100100;
            6:  glyph = 7'b0100000;  7:  glyph = 7'b0001111;
            8:  glyph = 7'b0000000;  9:  glyph = 7'b0000100;
            10: glyph = 7'b0001000;  11: glyph = 7'b1100000;
            12: glyph = 7'b0110001;  13: glyph = 7'b1000010;
            14: glyph = 7'b0110000;  default: glyph = 7'b0111000;
        endcase
    endfunction

    task automatic model_reset();
        m_value = '0;
        m_valid = '0;
        m_seen  = '0;
        m_lamp  = 1'b0;
    endtask

    // Drive the bus for n edges; a hold of at least 5 edges (STABLE_CYCLES+1) is one capture.
    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        logic [3:0] low;
        int idx, hv, cnt_low;
        bit found;
        an_n  = an;
        seg_n = seg;
        low   = ~an;
        if (n >= 5) begin
            cnt_low = $countones(low);
            if (low == 4'hF && seg == 7'b0000000) begin
`ifdef SEVEN_SEG_LAMP_TEST_EN
                m_lamp = 1'b1;
`else
                m_lamp = 1'b0;
`endif
            end else begin
                m_lamp = 1'b0;
                if (cnt_low == 1) begin
                    idx = 0;
                    for (int i = 0; i < 4; i++) if (low[i]) idx = i;
                    found = 1'b0;
                    hv = 0;
                    for (int h = 0; h < 16; h++) if (glyph(h) == seg) begin found = 1'b1; hv = h; end
                    if (found) begin
                        m_value[idx*4 +: 4] = 4'(hv);
                        m_valid[idx] = 1'b1;
                    end else if (seg == 7'h7F) begin
                        m_value[idx*4 +: 4] = 4'h0;
                        m_valid[idx] = 1'b0;
                    end else begin
                        m_valid[idx] = 1'b0;
                        err_q.push_back(idx);
                    end
                    m_seen[idx] = 1'b1;
                    if (m_seen == 4'hF) begin
                        frame_q.push_back(m_value);
                        m_seen = '0;
                    end
                end
            end
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_value"}, 32'(value), 32'(m_value));
        check({tag, "_valid"}, 32'(digit_valid), 32'(m_valid));
        check({tag, "_lamp"}, 32'(lamp_test), 32'(m_lamp));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (pattern_err) begin
                check("pattern_err_expected", 32'(err_q.size() != 0), 1);
                if (err_q.size() != 0) check("err_digit", 32'(err_digit), 32'(err_q.pop_front()));
            end
            if (frame_valid) begin
                check("frame_valid_expected", 32'(frame_q.size() != 0), 1);
                if (frame_q.size() != 0) check("frame_value", 32'(value), 32'(frame_q.pop_front()));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", 32'(value), 0);
        check("rst_valid", 32'(digit_valid), 0);
        check("rst_frame", 32'(frame_valid), 0);
        check("rst_perr", 32'(pattern_err), 0);
        check("rst_err_digit", 32'(err_digit), 0);
        check("rst_lamp", 32'(lamp_test), 0);
        reset = 1'b0;

        // Put stale data in, then reset while digit 0 is settling.
        hold(4'b1101, glyph(2), 8);
        check("pre_reset_value", 32'(value), 32'h0020);
        an_n  = 4'b1110;
        seg_n = glyph(1);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check("midrst_value", 32'(value), 0);
        check("midrst_valid", 32'(digit_valid), 0);
        check("midrst_lamp", 32'(lamp_test), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        hold(4'b1110, glyph(3), 8);
        check("post_reset_value", 32'(value), 32'h0003);
        check_state("post_reset");

        // Scan 1,2,3,4 across the digits; one frame after digit 3.
        hold(4'b1110, glyph(1), 8);
        hold(4'b1101, glyph(2), 8);
        hold(4'b1011, glyph(3), 8);
        hold(4'b0111, glyph(4), 8);
        check("scan_value", 32'(value), 32'h4321);
        check("scan_valid", 32'(digit_valid), 32'hF);
        check_state("scan");

        // Glitch rejection.
        hold(4'b1110, glyph(8), 8);
        hold(4'b1110, 7'b1111110, 3);
        hold(4'b1110, glyph(8), 8);
        check("glitch_value", 32'(value), 32'h4328);
        check_state("glitch");

        // Illegal glyph on digit 2.
        hold(4'b1011, 7'b1111110, 8);
        check("illegal_err_digit", 32'(err_digit), 2);
        check("illegal_value", 32'(value), 32'h4328);
        check_state("illegal");

        // Blank on digit 1, then two enables at once.
        hold(4'b1101, 7'b1111111, 8);
        check("blank_value", 32'(value), 32'h4308);
        check_state("blank");
        hold(4'b1100, glyph(7), 8);
        check_state("multi");

        // Lamp test pattern, then a normal digit clears it.
        hold(4'b0000, 7'b0000000, 8);
`ifdef SEVEN_SEG_LAMP_TEST_EN
        check("lamp_on", 32'(lamp_test), 1);
`else
        check("lamp_off", 32'(lamp_test), 0);
`endif
        check_state("lamp");
        hold(4'b1110, glyph(5), 8);
        check("lamp_clear", 32'(lamp_test), 0);
        check_state("after_lamp");

        // Digit 3 completes a frame that includes blank and error digits.
        hold(4'b0111, glyph(15), 8);
        hold(4'b1111, 7'h7F, 8);
        check("final_value", 32'(value), 32'hF305);
        check_state("final");
        check("err_q_drained", 32'(err_q.size()), 0);
        check("frame_q_drained", 32'(frame_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
